// File: rtl/seq_pkg.sv
// ----------------------------------------------------------------------------
// seq_pkg
// Shared types and widths for the microcode sequencer.
//   state_t    : FSM encoding (FETCH, EXEC, HALT). HALT is reachable only
//                when the design is built with SEQ_HALT_EN.
//   OPC_W      : opcode / operand nibble width
//   PROG_W     : program memory byte width
//   ROM_ADDR_W : microcode ROM address width {opcode, c, z, phase}
// ----------------------------------------------------------------------------
package seq_pkg;

    localparam int OPC_W      = 4;
    localparam int PROG_W     = 8;
    localparam int ROM_ADDR_W = 7;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_pc_counter.sv
// ----------------------------------------------------------------------------
// seq_pc_counter
// Program counter register. Load has priority over increment; increment
// wraps modulo 2^PC_W. Synchronous active-high reset clears the PC.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   en_i         : step qualifier; PC holds when low
//   inc_i        : increment strobe
//   load_i       : load strobe (wins over inc_i)
//   target_i     : load value
//   pc_o         : current program counter
// ----------------------------------------------------------------------------
module seq_pc_counter #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en_i) begin
            if (load_i) begin
                pc_d = target_i;
            end else if (inc_i) begin
                // Natural overflow gives the all-ones -> zero wrap.
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ucode_sequencer.sv
// ----------------------------------------------------------------------------
// ucode_sequencer
// Address stage in front of the 7-bit-in / 13-bit-out microcode ROM. Holds
// the PC, the instruction register, the carry/zero flags and the
// fetch/execute phase, and forms rom_addr = {opcode, c_flag, z_flag, phase}
// combinationally from those registers.
//
// Build option: SEQ_HALT_EN
//   defined   : an enabled EXECUTE step whose opcode equals HALT_OPCODE
//               enters HALT; everything freezes until reset; halted=1.
//   undefined : no HALT state, HALT_OPCODE parameter absent, halted=0.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   enable           : step qualifier; all state holds when low
//   prog_byte        : program memory data at pc ([7:4] opcode, [3:0] operand)
//   pc_inc, pc_load  : PC strobes from the ROM (load wins)
//   pc_target        : jump address
//   flags_load       : capture alu_c / alu_z this step
//   alu_c, alu_z     : ALU carry / zero
//   pc               : program counter
//   opcode, operand  : instruction register nibbles
//   c_flag, z_flag   : registered flags
//   phase            : 0 = FETCH, 1 = EXECUTE (stays 1 while halted)
//   rom_addr         : microcode ROM address
//   halted           : sequencer stopped
//
// Handshake: there is no valid/ready pair; every rising edge with
// enable=1 (and not halted) is exactly one step, strobes are sampled on that
// edge, and new state is visible on the outputs right after the edge.
// ----------------------------------------------------------------------------
module ucode_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = 12
`ifdef SEQ_HALT_EN
    ,
    parameter logic [OPC_W-1:0] HALT_OPCODE = 4'hF
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [PROG_W-1:0]     prog_byte,
    input  logic                  pc_inc,
    input  logic                  pc_load,
    input  logic [PC_W-1:0]       pc_target,
    input  logic                  flags_load,
    input  logic                  alu_c,
    input  logic                  alu_z,
    output logic [PC_W-1:0]       pc,
    output logic [OPC_W-1:0]      opcode,
    output logic [OPC_W-1:0]      operand,
    output logic                  c_flag,
    output logic                  z_flag,
    output logic                  phase,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    output logic                  halted
);

    state_t            state_q, state_d;
    logic [PROG_W-1:0] ir_q, ir_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic              step;

    // A step is an enabled edge outside HALT; strobes only act on steps.
    assign step = enable && (state_q != HALT);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        c_d     = c_q;
        z_d     = z_q;

        if (step) begin
            if (flags_load) begin
                c_d = alu_c;
                z_d = alu_z;
            end

            case (state_q)
                FETCH: begin
                    ir_d    = prog_byte;
                    state_d = EXEC;
                end
                EXEC: begin
`ifdef SEQ_HALT_EN
                    if (ir_q[PROG_W-1:OPC_W] == HALT_OPCODE) begin
                        state_d = HALT;
                    end else begin
                        state_d = FETCH;
                    end
`else
                    state_d = FETCH;
`endif
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            c_q     <= c_d;
            z_q     <= z_d;
        end
    end

    seq_pc_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .en_i     (step),
        .inc_i    (pc_inc),
        .load_i   (pc_load),
        .target_i (pc_target),
        .pc_o     (pc)
    );

    assign opcode  = ir_q[PROG_W-1:OPC_W];
    assign operand = ir_q[OPC_W-1:0];
    assign c_flag  = c_q;
    assign z_flag  = z_q;
    // HALT is only entered from EXECUTE, so the phase bit stays frozen at 1.
    assign phase   = (state_q != FETCH);
`ifdef SEQ_HALT_EN
    assign halted  = (state_q == HALT);
`else
    assign halted  = 1'b0;
`endif
    assign rom_addr = {opcode, c_q, z_q, phase};

endmodule
